lt24_touch_sampler: RTL
=======================

// Module: lt24_touch_sampler
// PURPOSE
//   Touch front-end for the LT24 resistive panel ADC (ADS7843-class, SPI).
//   Debounces PENIRQ_N, runs X/Y 12-bit conversions while the pen is down and
//   exposes results to the Nios II through a 4-word Avalon-MM slave with IRQ.
//   It sits on the same LT24_ADC pins as the IRQ_N input PIO and feeds the touch driver.
// PARAMETERS
//   CLK_DIV        25      clk cycles per DCLK half-period (50 MHz -> 1 MHz DCLK)
//   DEBOUNCE_CYC   50000   consecutive stable synced PENIRQ_N cycles for pen down/up
//   SAMPLE_PERIOD  500000  clk cycles from one X/Y pair start to the next while pen is down
// PORTS
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   address        in   2   Avalon word address
//   read           in   1   Avalon read strobe
//   write          in   1   Avalon write strobe
//   writedata      in   32  Avalon write data
//   readdata       out  32  Avalon read data, registered, 1-cycle latency
//   irq            out  1   level IRQ = data_valid & irq_en, registered
//   adc_penirq_n   in   1   pen interrupt from ADC (async, low = touched)
//   adc_dout       in   1   ADC serial data out (async)
//   adc_cs_n       out  1   ADC chip select, active low
//   adc_dclk       out  1   ADC serial clock, idles low
//   adc_din        out  1   ADC serial command in
// BEHAVIOUR
//   Reset: readdata=0, irq=0, adc_cs_n=1, adc_dclk=0, adc_din=0; X=Y=0, pen_down=0,
//     data_valid=0, enable=0, irq_en=0, state IDLE. Reset mid-transfer aborts immediately.
//   adc_penirq_n, adc_dout: 2-flop synchronizers before any use.
//   Registers: 0 STATUS RO [0]pen_down [1]data_valid [2]busy; write [1]=1 clears data_valid.
//     1 DATA RO [11:0]X [27:16]Y; a read clears data_valid. 2 CTRL RW [0]enable [1]irq_en.
//     3 SAMPLES RO 16-bit count of completed pairs, wraps 0xFFFF->0. Unused bits read 0.
//   FSM: IDLE -> (enable & synced penirq_n low) DEBOUNCE; DEBOUNCE counts low cycles,
//     any high returns to IDLE, reaching DEBOUNCE_CYC sets pen_down -> CONV.
//     CONV: cs_n low, CLK_DIV setup cycles, then X frame (cmd 0xD0) then Y frame (cmd 0x90),
//     no gap; cs_n high after Y frame + CLK_DIV cycles -> DONE (1 cycle) -> WAIT.
//     WAIT: period counter from CONV start; at SAMPLE_PERIOD -> CONV. Synced penirq_n high
//     DEBOUNCE_CYC consecutive cycles -> pen_down=0, IDLE. PENIRQ ignored during CONV.
//   Frame: 24 DCLK periods; din changes after falling edge, cmd MSB first in periods 1-8,
//     din=0 afterwards; dout sampled on rising edges 10..21, MSB first -> 12-bit result.
//   DONE: X,Y latched together (never torn), data_valid set, SAMPLES+1.
//   busy = 1 in CONV/DONE. enable cleared in CONV: pair completes, then IDLE, pen_down=0.
//   Same-cycle set vs clear of data_valid (DATA read or STATUS write): set wins;
//     the read returns the previous X/Y.
//   SAMPLE_PERIOD shorter than a pair: next CONV starts right after DONE.
// TESTING
//   CLK_DIV=2, DEBOUNCE_CYC=8, SAMPLE_PERIOD=400 for all benches.
//   1 ADC model returns X=0xABC,Y=0x123; enable, hold penirq_n low -> after 8 stable
//     cycles cs_n falls, din shows 0xD0 then 0x90, DATA reads 0x0123_0ABC, irq=1 if irq_en.
//   2 penirq_n low 5 cycles then high -> no cs_n activity, pen_down stays 0.
//   3 pen held: successive cs_n falling edges exactly 400 clk apart; SAMPLES increments each.
//   4 DATA read on the DONE cycle -> readdata = old pair, data_valid stays 1, irq stays 1.
//   5 assert reset mid-X-frame -> cs_n=1, dclk=0, all registers 0 next clock;
//     release with pen down -> fresh debounce.
//   6 penirq_n high >=8 cycles in WAIT -> pen_down=0, IDLE; STATUS write 0x2 clears irq.

Source files
------------

// File: rtl/lt24_touch_sampler_if.sv
// Avalon-MM register port between the touch sampler and the Nios II.
// Latency: readdata is valid the cycle after the read strobe; irq is a registered level.
// Backpressure: none, the slave never stalls (no waitrequest).
// Ports: address[1:0], read, write, writedata[31:0] (master->slave);
//        readdata[31:0], irq (slave->master).
interface lt24_touch_sampler_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, read, write, writedata, input readdata, irq);
  modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/lt24_touch_sampler.sv
// LT24 resistive touch front-end: debounces PENIRQ_N, runs X/Y 12-bit SPI conversions, Avalon-MM regs + IRQ.
// Latency: readdata 1 cycle after read; pen-down detect = 2 sync + DEBOUNCE_CYC cycles; pair = (98*CLK_DIV) cycles.
// Backpressure: none; register accesses always complete, conversions run on their own schedule.
// Ports: clk, reset (async, active high); avs = Avalon slave (address/read/write/writedata/readdata/irq);
//        adc_penirq_n, adc_dout (async inputs); adc_cs_n, adc_dclk, adc_din (SPI to the ADC).
module lt24_touch_sampler #(
  parameter int CLK_DIV       = 25,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int SAMPLE_PERIOD = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  lt24_touch_sampler_if.slave   avs,
  input  logic                  adc_penirq_n,
  input  logic                  adc_dout,
  output logic                  adc_cs_n,
  output logic                  adc_dclk,
  output logic                  adc_din
);
  localparam int TW  = $clog2(CLK_DIV + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PW  = $clog2(SAMPLE_PERIOD + 1);

  typedef enum logic [2:0] {S_IDLE, S_DEBOUNCE, S_CONV, S_DONE, S_WAIT} state_t;
  typedef enum logic [1:0] {P_SETUP, P_XFER, P_TRAIL} phase_t;

  state_t          state, state_nx;
  phase_t          phase;
  logic            pen_meta, pen_s, dout_meta, dout_s;
  logic [DBW-1:0]  deb_cnt;
  logic [PW-1:0]   period_cnt;
  logic [TW-1:0]   tick;
  logic [6:0]      half;          // DCLK half-period index across both frames (0..95)
  logic [1:0]      samp_pipe;
  logic [11:0]     shreg, x_tmp, x_q, y_q;
  logic [15:0]     samples;
  logic            pen_down, data_valid, enable, irq_en;
  logic            tick_end, deb_end, period_hit, conv_end, samp_now, busy, dv_clr;
  logic [5:0]      cur_p, bit_idx;
  logic [31:0]     rd_mux;
  logic            unused_wd;

  assign unused_wd = ^avs.writedata[31:2];

  // Command bit driven during DCLK period p (0-based over both frames).
  function automatic logic din_for(input logic [5:0] p);
    logic [5:0] b;
    logic [7:0] cmd;
    b   = (p >= 6'd24) ? p - 6'd24 : p;
    cmd = (p >= 6'd24) ? 8'h90 : 8'hD0;
    return (b < 6'd8) ? cmd[3'd7 - b[2:0]] : 1'b0;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {pen_meta, pen_s}   <= 2'b11;
      {dout_meta, dout_s} <= 2'b00;
    end else begin
      {pen_meta, pen_s}   <= {adc_penirq_n, pen_meta};
      {dout_meta, dout_s} <= {adc_dout, dout_meta};
    end
  end

  assign tick_end   = (tick == TW'(CLK_DIV - 1));
  assign deb_end    = (deb_cnt >= DBW'(DEBOUNCE_CYC - 1));
  assign period_hit = (period_cnt >= PW'(SAMPLE_PERIOD - 1));
  assign conv_end   = (state == S_CONV) && (phase == P_TRAIL) && tick_end;
  assign busy       = (state == S_CONV) || (state == S_DONE);
  assign cur_p      = half[6:1];
  assign bit_idx    = (cur_p >= 6'd24) ? cur_p - 6'd24 : cur_p;
  // Rising DCLK edges of periods 10..21 in each frame carry the result bits.
  assign samp_now   = (state == S_CONV) && (phase == P_XFER) && tick_end && !half[0] &&
                      (bit_idx >= 6'd9) && (bit_idx <= 6'd20);
  assign dv_clr     = (avs.read && avs.address == 2'd1) ||
                      (avs.write && avs.address == 2'd0 && avs.writedata[1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (enable && !pen_s) state_nx = S_DEBOUNCE;
      S_DEBOUNCE: if (!enable || pen_s) state_nx = S_IDLE;
                  else if (deb_end)     state_nx = S_CONV;
      S_CONV:     if (conv_end)         state_nx = S_DONE;
      S_DONE:     if (!enable)          state_nx = S_IDLE;
                  else if (period_hit)  state_nx = S_CONV;
                  else                  state_nx = S_WAIT;
      S_WAIT:     if (!enable || (pen_s && deb_end)) state_nx = S_IDLE;
                  else if (period_hit)  state_nx = S_CONV;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (avs.address)
      2'd0:    rd_mux = {29'd0, busy, data_valid, pen_down};
      2'd1:    rd_mux = {4'd0, y_q, 4'd0, x_q};
      2'd2:    rd_mux = {30'd0, irq_en, enable};
      default: rd_mux = {16'd0, samples};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt <= '0;  period_cnt <= '0;  phase <= P_SETUP;  tick <= '0;  half <= '0;
      samp_pipe <= '0;  shreg <= '0;  x_tmp <= '0;  x_q <= '0;  y_q <= '0;  samples <= '0;
      adc_cs_n <= 1'b1;  adc_dclk <= 1'b0;  adc_din <= 1'b0;
      pen_down <= 1'b0;  data_valid <= 1'b0;  enable <= 1'b0;  irq_en <= 1'b0;
      avs.readdata <= '0;  avs.irq <= 1'b0;
    end else begin
      // Pen-down counts low cycles (IDLE cycle is the first); pen-up counts high cycles in WAIT.
      case (state)
        S_IDLE:     deb_cnt <= DBW'(1);
        S_DEBOUNCE: deb_cnt <= deb_cnt + 1'b1;
        S_WAIT:     deb_cnt <= pen_s ? deb_cnt + 1'b1 : '0;
        default:    deb_cnt <= '0;
      endcase

      if (state != S_CONV && state_nx == S_CONV) period_cnt <= '0;
      else if (!period_hit)                      period_cnt <= period_cnt + 1'b1;

      if (state == S_DEBOUNCE && state_nx == S_CONV) pen_down <= 1'b1;
      else if (state_nx == S_IDLE)                   pen_down <= 1'b0;

      // dout passes a 2-flop synchronizer, so capture 2 cycles after the rising edge.
      samp_pipe <= {samp_pipe[0], samp_now};
      if (samp_pipe[1]) shreg <= {shreg[10:0], dout_s};

      if (state != S_CONV && state_nx == S_CONV) begin
        adc_cs_n <= 1'b0;  adc_dclk <= 1'b0;  adc_din <= 1'b0;
        phase <= P_SETUP;  tick <= '0;  half <= '0;
      end else if (state == S_CONV) begin
        if (!tick_end) begin
          tick <= tick + 1'b1;
        end else begin
          tick <= '0;
          case (phase)
            P_SETUP: begin
              phase   <= P_XFER;
              adc_din <= din_for(6'd0);
            end
            P_XFER: begin
              if (!half[0]) begin
                adc_dclk <= 1'b1;
                half     <= half + 7'd1;
              end else begin
                adc_dclk <= 1'b0;
                if (half == 7'd47) x_tmp <= shreg;
                if (half == 7'd95) begin
                  phase   <= P_TRAIL;
                  adc_din <= 1'b0;
                end else begin
                  half    <= half + 7'd1;
                  adc_din <= din_for(half[6:1] + 6'd1);
                end
              end
            end
            default: adc_cs_n <= 1'b1;
          endcase
        end
      end

      // X and Y update in the same cycle so a reader never sees a torn pair.
      if (state == S_DONE) begin
        x_q     <= x_tmp;
        y_q     <= shreg;
        samples <= samples + 16'd1;
      end

      if (state == S_DONE) data_valid <= 1'b1;
      else if (dv_clr)     data_valid <= 1'b0;

      if (avs.write && avs.address == 2'd2) begin
        enable <= avs.writedata[0];
        irq_en <= avs.writedata[1];
      end

      if (avs.read) avs.readdata <= rd_mux;
      avs.irq <= data_valid & irq_en;
    end
  end
endmodule
